// File: rtl/snes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snes_pkg                                                     |
// | Description : Shared types and constants for the SNES pad responder.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package snes_pkg;

  localparam int FRAME_BITS = 16;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam logic [3:0] C_UNUSED_FILL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } snes_state_t;

  // Pressed buttons read as 0 on the wire; the four spare bits read as released.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [11:0] buttons);
    return {C_UNUSED_FILL, ~buttons};
  endfunction

endpackage
`default_nettype wire

// File: rtl/snes_strobe_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snes_strobe_filter                                           |
// | Description : 2-FF synchronizer, stability filter and edge pulses.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module snes_strobe_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_strobe,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic       r_sync_meta;
  logic       r_sync;
  logic       r_level;
  logic       r_rise;
  logic       r_fall;
  logic [7:0] r_count;
  logic [7:0] w_count_inc;
  logic       w_accept;

  assign w_count_inc = r_count + 8'd1;
  assign w_accept    = (r_sync != r_level) && (w_count_inc == 8'(FILTER_CYCLES));

  // Edge pulses are produced in the same cycle the filtered level flips.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
      r_level     <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_count     <= 8'd0;
    end else begin
      r_sync_meta <= i_strobe;
      r_sync      <= r_sync_meta;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      if (r_sync != r_level) begin
        if (w_accept) begin
          r_level <= r_sync;
          r_rise  <= r_sync;
          r_fall  <= ~r_sync;
          r_count <= 8'd0;
        end else begin
          r_count <= w_count_inc;
        end
      end else begin
        r_count <= 8'd0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/snes_controller_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snes_controller_responder                                    |
// | Description : SNES joypad end: shifts a 16-bit button frame on strobes.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module snes_controller_responder
  import snes_pkg::*;
#(
  parameter int   FILTER_CYCLES = 4,
  parameter logic TRAIL_LEVEL   = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        controller_latch,
  input  logic        controller_clock,
  input  logic [11:0] buttons,
  input  logic        connected,
  output logic        controller_data,
  output logic        frame_done,
  output logic [4:0]  bit_index
);

  logic                  r_rst_meta_n;
  logic                  r_rst_n;
  snes_state_t           r_state;
  snes_state_t           w_state_next;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_shift_next;
  logic [4:0]            r_bit_index;
  logic [4:0]            w_bit_index_next;
  logic                  r_frame_done;
  logic                  w_frame_done_next;
  logic                  r_data;
  logic                  w_data_next;
  logic                  w_latch_level;
  logic                  w_latch_rise;
  logic                  w_latch_fall;
  logic                  w_clock_level;
  logic                  w_clock_rise;
  logic                  w_clock_fall;
  logic                  w_clock_edge;

  // Reset asserts immediately and releases on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta_n <= 1'b0;
      r_rst_n      <= 1'b0;
    end else begin
      r_rst_meta_n <= 1'b1;
      r_rst_n      <= r_rst_meta_n;
    end
  end

  snes_strobe_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_latch_filter (
    .clock    (clock),
    .reset_n  (r_rst_n),
    .i_strobe (controller_latch),
    .o_level  (w_latch_level),
    .o_rise   (w_latch_rise),
    .o_fall   (w_latch_fall)
  );

  snes_strobe_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clock_filter (
    .clock    (clock),
    .reset_n  (r_rst_n),
    .i_strobe (controller_clock),
    .o_level  (w_clock_level),
    .o_rise   (w_clock_rise),
    .o_fall   (w_clock_fall)
  );

  // A filtered rise always coincides with a high level and no fall.
  assign w_clock_edge = w_clock_rise && w_clock_level && !w_clock_fall;

  always_comb begin
    w_state_next      = r_state;
    w_shift_next      = r_shift;
    w_bit_index_next  = r_bit_index;
    w_frame_done_next = 1'b0;
    if (w_latch_rise) begin
      w_state_next     = ST_LOAD;
      w_shift_next     = build_frame(buttons);
      w_bit_index_next = 5'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_latch_level) w_state_next = ST_LOAD;
        end
        ST_LOAD: begin
          w_shift_next     = build_frame(buttons);
          w_bit_index_next = 5'd0;
          if (w_latch_fall) w_state_next = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_clock_edge) begin
            w_shift_next     = {1'b1, r_shift[FRAME_BITS-1:1]};
            w_bit_index_next = r_bit_index + 5'd1;
            if (r_bit_index == 5'(FRAME_BITS - 1)) begin
              w_state_next      = ST_DONE;
              w_frame_done_next = 1'b1;
            end
          end
        end
        ST_DONE: begin
          w_bit_index_next = 5'(FRAME_BITS);
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_data_next = 1'b1;
    unique case (r_state)
      ST_IDLE:  w_data_next = 1'b1;
      ST_LOAD:  w_data_next = r_shift[0];
      ST_SHIFT: w_data_next = r_shift[0];
      ST_DONE:  w_data_next = TRAIL_LEVEL;
      default:  w_data_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '1;
      r_bit_index  <= 5'd0;
      r_frame_done <= 1'b0;
      r_data       <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_bit_index  <= w_bit_index_next;
      r_frame_done <= w_frame_done_next;
      r_data       <= w_data_next;
    end
  end

  assign controller_data = r_data | ~connected;
  assign frame_done      = r_frame_done;
  assign bit_index       = r_bit_index;

endmodule
`default_nettype wire

// File: tb/tb_snes_controller_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_snes_controller_responder                                 |
// | Description : Directed + randomized bench for the SNES pad responder.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_snes_controller_responder;

  localparam int   FILTER_CYCLES = 4;
  localparam logic TRAIL_LEVEL   = 1'b0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        controller_latch = 1'b0;
  logic        controller_clock = 1'b0;
  logic [11:0] buttons = 12'h000;
  logic        connected = 1'b1;
  logic        controller_data;
  logic        frame_done;
  logic [4:0]  bit_index;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int d0;
  logic [11:0] b, b2;

  snes_controller_responder #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .TRAIL_LEVEL   (TRAIL_LEVEL)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .controller_latch (controller_latch),
    .controller_clock (controller_clock),
    .buttons          (buttons),
    .connected        (connected),
    .controller_data  (controller_data),
    .frame_done       (frame_done),
    .bit_index        (bit_index)
  );

  always #15 clock = ~clock;

  always @(posedge clock) if (frame_done === 1'b1) done_count <= done_count + 1;

  // Reference: pressed buttons are 0 on the wire, LSB first, slots 12..15 released.
  function automatic logic expected_bit(input logic [11:0] btn, input int idx);
    if (idx >= 12) return 1'b1;
    return btn[idx] ? 1'b0 : 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic latch_pulse();
    controller_latch = 1'b1;
    idle(10);
    controller_latch = 1'b0;
    idle(10);
  endtask

  task automatic clock_pulse(input int hi, input int lo);
    controller_clock = 1'b1;
    idle(hi);
    controller_clock = 1'b0;
    idle(lo);
  endtask

  task automatic shift_checked(input logic [11:0] btn, input int first, input int count,
                               input string tag);
    for (int i = first; i < first + count; i++) begin
      check($sformatf("%s_idx%0d", tag, i), 32'(bit_index), 32'(i));
      check($sformatf("%s_bit%0d", tag, i), 32'(controller_data), 32'(expected_bit(btn, i)));
      clock_pulse(6, 8);
    end
  endtask

  task automatic frame_end(input string tag, input int start_done);
    check({tag, "_done_once"}, 32'(done_count - start_done), 32'd1);
    check({tag, "_trail"}, 32'(controller_data), 32'(TRAIL_LEVEL));
    check({tag, "_idx16"}, 32'(bit_index), 32'd16);
  endtask

  initial begin
    // Reset held while strobes toggle
    reset_n = 1'b0;
    repeat (4) begin
      controller_latch = ~controller_latch;
      controller_clock = ~controller_clock;
      idle(3);
      check("rst_data", 32'(controller_data), 32'd1);
      check("rst_idx", 32'(bit_index), 32'd0);
    end
    controller_latch = 1'b0;
    controller_clock = 1'b0;
    idle(10);
    check("rst_done", 32'(done_count), 32'd0);
    reset_n = 1'b1;
    idle(10);
    check("idle_data", 32'(controller_data), 32'd1);

    // Single B press
    buttons = 12'h001;
    latch_pulse();
    d0 = done_count;
    shift_checked(12'h001, 0, 16, "btnB");
    frame_end("btnB", d0);

    // Pattern ordering plus extra clocks after the frame
    buttons = 12'hA5C;
    latch_pulse();
    d0 = done_count;
    shift_checked(12'hA5C, 0, 16, "a5c");
    repeat (3) clock_pulse(6, 8);
    frame_end("a5c_extra", d0);

    // Random frames; buttons change mid-frame and must not leak in
    repeat (4) begin
      b = 12'($urandom);
      buttons = b;
      latch_pulse();
      buttons = 12'($urandom);
      d0 = done_count;
      shift_checked(b, 0, 16, "rand");
      frame_end("rand", d0);
    end

    // Glitch rejection
    b = 12'($urandom);
    buttons = b;
    latch_pulse();
    clock_pulse(3, 10);
    check("glitch3_idx", 32'(bit_index), 32'd0);
    clock_pulse(5, 10);
    check("pulse5_idx", 32'(bit_index), 32'd1);
    check("pulse5_bit", 32'(controller_data), 32'(expected_bit(b, 1)));

    // Abort after 7 clocks with new buttons
    shift_checked(b, 1, 6, "pre_abort");
    d0 = done_count;
    b2 = 12'($urandom);
    buttons = b2;
    latch_pulse();
    check("abort_idx", 32'(bit_index), 32'd0);
    check("abort_nodone", 32'(done_count - d0), 32'd0);
    check("abort_bit0", 32'(controller_data), 32'(expected_bit(b2, 0)));
    shift_checked(b2, 0, 16, "post_abort");
    frame_end("post_abort", d0);

    // Latch and clock rising together: latch wins
    b = 12'($urandom);
    buttons = b;
    latch_pulse();
    shift_checked(b, 0, 3, "pre_sim");
    b2 = 12'($urandom);
    buttons = b2;
    controller_latch = 1'b1;
    controller_clock = 1'b1;
    idle(10);
    controller_latch = 1'b0;
    idle(10);
    controller_clock = 1'b0;
    idle(10);
    check("simul_idx", 32'(bit_index), 32'd0);
    check("simul_bit0", 32'(controller_data), 32'(expected_bit(b2, 0)));
    d0 = done_count;
    shift_checked(b2, 0, 16, "post_sim");
    frame_end("post_sim", d0);

    // Unplug mid-frame
    b = 12'($urandom);
    buttons = b;
    latch_pulse();
    d0 = done_count;
    shift_checked(b, 0, 5, "pre_unplug");
    connected = 1'b0;
    #1;
    check("unplug_data", 32'(controller_data), 32'd1);
    idle(1);
    repeat (2) clock_pulse(6, 8);
    check("unplug_idx", 32'(bit_index), 32'd7);
    check("unplug_data2", 32'(controller_data), 32'd1);
    connected = 1'b1;
    #1;
    check("replug_bit7", 32'(controller_data), 32'(expected_bit(b, 7)));
    idle(1);
    shift_checked(b, 7, 9, "post_unplug");
    frame_end("post_unplug", d0);

    // Async reset at bit 9
    b = 12'($urandom);
    buttons = b;
    latch_pulse();
    shift_checked(b, 0, 9, "pre_reset");
    check("pre_reset_idx", 32'(bit_index), 32'd9);
    reset_n = 1'b0;
    #1;
    check("async_rst_data", 32'(controller_data), 32'd1);
    check("async_rst_idx", 32'(bit_index), 32'd0);
    check("async_rst_done", 32'(frame_done), 32'd0);
    idle(3);
    reset_n = 1'b1;
    idle(10);
    repeat (2) clock_pulse(6, 8);
    check("post_rst_idle_idx", 32'(bit_index), 32'd0);
    check("post_rst_idle_data", 32'(controller_data), 32'd1);
    b = 12'($urandom);
    buttons = b;
    latch_pulse();
    d0 = done_count;
    shift_checked(b, 0, 16, "post_rst");
    frame_end("post_rst", d0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
